// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b - bi (mod 2^WIDTH), bo = borrow out.
// Operands and result move through valid/ready handshakes; one bit is processed per clock, LSB first.
module serial_subtractor #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bo
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, next_state;
  logic [WIDTH-1:0]   a_sr, b_sr, diff_r;
  logic               borrow, bo_r;
  logic [CNT_W-1:0]   cnt;

  logic x, y, d, r_next, last_bit;

  // Full-subtractor cell applied to the current LSBs.
  assign x        = a_sr[0];
  assign y        = b_sr[0];
  assign d        = x ^ y ^ borrow;
  assign r_next   = (~x & y) | (~(x ^ y) & borrow);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = SHIFT;
      end
      SHIFT: begin
        if (last_bit) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      diff_r <= '0;
      borrow <= 1'b0;
      bo_r   <= 1'b0;
      cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= bi;
            cnt    <= '0;
          end
        end
        SHIFT: begin
          diff_r <= {d, diff_r[WIDTH-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          borrow <= r_next;
          cnt    <= cnt + CNT_W'(1);
          // bo only moves on the final bit so it keeps the last result while idle.
          if (last_bit) bo_r <= r_next;
        end
        default: ;
      endcase
    end
  end

  assign diff = diff_r;
  assign bo   = bo_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, backpressure, mid-operation reset
// and a randomized run, all compared through an expected-result queue.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             bi;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bo;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bi(bi),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bo(bo)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int accept_cycle = -1;
  logic prev_valid = 1'b0;

  logic [WIDTH:0] sb[$];

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bi;
    logic [WIDTH-1:0] exp_diff;
    logic             exp_bo;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cycle++;

  // Monitor: latency on out_valid rise, scoreboard pop on each transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !prev_valid)
        check("latency", 32'(cycle - accept_cycle), 32'(WIDTH));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_result", 32'(1), 32'(0));
        else begin
          logic [WIDTH:0] e;
          e = sb.pop_front();
          check("result_bo_diff", 32'({bo, diff}), 32'(e));
        end
      end
    end
    prev_valid = out_valid;
  end

  // Drive one operation; push the expected result at the accepting edge.
  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                      input logic tbi, input logic [WIDTH:0] exp);
    bit ok = 0;
    a = ta; b = tb_; bi = tbi; in_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (in_ready) begin
        sb.push_back(exp);
        accept_cycle = cycle + 1;
        ok = 1;
      end
      @(posedge clk); #1;
      if (ok) break;
    end
    if (!ok) check("accept_timeout", 32'(0), 32'(1));
    in_valid = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); bi = 1'($urandom);
  endtask

  task automatic wait_xfer(input bit rand_ready);
    bit done = 0;
    for (int n = 0; n < 300; n++) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      done = out_valid && out_ready;
      @(posedge clk); #1;
      if (done) break;
    end
    if (!done) check("xfer_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_valid();
    bit seen = 0;
    for (int n = 0; n < 100; n++) begin
      if (out_valid) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    if (!seen) check("valid_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    vec_t vecs[5];
    vecs[0] = '{8'hA1, 8'hBF, 1'b1, 8'hE1, 1'b1};
    vecs[1] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{8'h00, 8'h01, 1'b1, 8'hFE, 1'b1};
    vecs[3] = '{8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0};
    vecs[4] = '{8'h35, 8'h23, 1'b0, 8'h12, 1'b0};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bi = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_diff", 32'(diff), 32'(0));
    check("rst_bo", 32'(bo), 32'(0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Vector table
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].bi, {vecs[i].exp_bo, vecs[i].exp_diff});
      wait_xfer(0);
    end

    // Backpressure with ignored in_valid pulse during SHIFT
    out_ready = 1'b0;
    send(8'h12, 8'h23, 1'b0, {1'b1, 8'hEF});
    a = 8'hFF; b = 8'h00; bi = 1'b1; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      check("bp_out_valid", 32'(out_valid), 32'(1));
      check("bp_in_ready", 32'(in_ready), 32'(0));
      check("bp_diff", 32'(diff), 32'(8'hEF));
      check("bp_bo", 32'(bo), 32'(1));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 32'(in_ready), 32'(1));
    check("bp_release_out_valid", 32'(out_valid), 32'(0));
    check("bp_sb_drained", 32'(sb.size()), 32'(0));

    // Asynchronous reset mid-SHIFT
    send(8'hA1, 8'hBF, 1'b0, {1'b1, 8'hE2});
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'(0));
    check("mid_rst_in_ready", 32'(in_ready), 32'(1));
    check("mid_rst_diff", 32'(diff), 32'(0));
    check("mid_rst_bo", 32'(bo), 32'(0));
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < WIDTH + 4; k++) begin
      check("post_rst_no_result", 32'(out_valid), 32'(0));
      @(posedge clk); #1;
    end
    send(8'hA1, 8'hBF, 1'b0, {1'b1, 8'hE2});
    wait_xfer(0);

    // Randomized back-to-back run with random out_ready
    for (int i = 0; i < 1000; i++) begin
      logic [WIDTH-1:0] ra, rb;
      logic             rbi;
      logic [WIDTH:0]   e;
      ra = WIDTH'($urandom); rb = WIDTH'($urandom); rbi = 1'($urandom);
      e = {1'b0, ra} - {1'b0, rb} - {{WIDTH{1'b0}}, rbi};
      send(ra, rb, rbi, e);
      wait_xfer(1);
    end
    check("final_sb_empty", 32'(sb.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor with borrow-in and borrow-out. It is the inverse companion of the combinational ripple adder.
- Computes diff = a - b - bi and bo (borrow out), one bit per clock, LSB first.
- Operands enter through a valid/ready input handshake. The result leaves through a valid/ready output handshake.
- Used where area matters more than throughput, and as a self-checking counterpart to the adder (a + b + ci recoverable via subtract).

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)
CNT_W, $clog2(WIDTH+1), bit counter width (derived; not to be overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  operands a, b, bi valid
in_ready  output  1  block can accept operands
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bi  input  1  borrow in
out_valid  output  1  diff/bo valid
out_ready  input  1  consumer accepts result
diff  output  WIDTH  a - b - bi modulo 2^WIDTH
bo  output  1  borrow out; 1 when a < b + bi (unsigned)

Behaviour:
- One clock (clk). Reset rst is asynchronous, active-high; all state clears immediately on assertion, independent of clk.
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0
  - diff = 0, bo = 0
  - internal a/b shift registers, borrow flop and counter = 0
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On an edge with in_valid = 1: latch a, b into shift registers, borrow flop <= bi, counter <= 0, go to SHIFT.
  - in_valid = 0 holds IDLE.
- SHIFT:
  - in_ready = 0, out_valid = 0; in_valid is ignored.
  - Each edge, with x = a_sr[0], y = b_sr[0], r = borrow flop:
    - d = x ^ y ^ r
    - r_next = (~x & y) | (~(x ^ y) & r)
    - diff register shifts right with d entering the MSB
    - a_sr and b_sr shift right (zero fill)
    - borrow <= r_next, counter += 1
  - On the edge where counter reaches WIDTH-1 (the WIDTH-th bit), go to DONE. bo takes r_next of that edge.
- DONE:
  - out_valid = 1; diff and bo stable.
  - On an edge with out_ready = 1: go to IDLE; in_ready = 1 from the following cycle.
  - out_ready = 0 holds DONE indefinitely with outputs unchanged (backpressure).
- Latency:
  - Operands accepted at edge T0 -> out_valid high after edge T0+WIDTH.
  - Result transferred at first edge with out_valid & out_ready.
  - Next accept no earlier than the edge after that.
- Throughput: one operation per WIDTH+2 cycles minimum. No overlap, no internal queueing.
- diff and bo are only meaningful while out_valid = 1. They retain the last result in IDLE until the next operation starts shifting.
- out_ready asserted outside DONE has no effect.
- Arithmetic is unsigned modulo 2^WIDTH.
- Identity: when bo = 0, diff + b + bi = a; when bo = 1, diff + b + bi = a + 2^WIDTH.
- Reset mid-operation (SHIFT or DONE): the operation is abandoned, outputs go to reset values, and no result is produced.
- Inputs a/b/bi may change freely after acceptance without affecting the result.

Test Plan:
- Reset, then a=8'hA1, b=8'hBF, bi=1, out_ready=1 -> out_valid exactly 8 cycles after accept, diff=8'hE1, bo=1.
- a=8'h00, b=8'h00, bi=0 -> diff=8'h00, bo=0; a=8'h00, b=8'h01, bi=1 -> diff=8'hFE, bo=1.
- a=8'hFF, b=8'h01, bi=0 -> diff=8'hFE, bo=0; a=8'h35, b=8'h23, bi=0 -> diff=8'h12, bo=0.
- Backpressure: a=8'h12, b=8'h23, bi=0, out_ready=0 for 5 cycles after out_valid.
  - Required: diff=8'hEF, bo=1 held stable, in_ready=0 throughout.
  - Then out_ready=1 -> IDLE, in_ready=1 next cycle.
  - in_valid pulsed during SHIFT is ignored (result unchanged).
- Reset mid-SHIFT: start a=8'hA1, b=8'hBF, bi=0, assert rst asynchronously (between edges) after 3 cycles.
  - Required: out_valid=0, in_ready=1, diff=0, bo=0 immediately; no result after release.
  - Next op a=8'hA1, b=8'hBF, bi=0 -> diff=8'hE2, bo=1.
- Randomized check: 1000 random a/b/bi, back-to-back with random out_ready.
  - Required: {bo, diff} == ({1'b0, a} - b - bi) mod 2^9 for every transfer.
  - Required: out_valid rises exactly WIDTH cycles after each accept.
